// File: rtl/guess_game_if.sv
// Board-side bundle of the guessing game engine: raw buttons and switches
// in, registered score/round status and display controls out.
interface guess_game_if #(
   parameter int WIDTH     = 4,
   parameter int MAX_TRIES = 7
);
   localparam int TW = $clog2(MAX_TRIES + 1);

   logic             store_n;
   logic             submit_n;
   logic             reveal_n;
   logic [WIDTH-1:0] secret_in;
   logic [WIDTH-1:0] guess_in;
   logic [WIDTH-1:0] secret_out;
   logic             eq;
   logic             gt;
   logic             lt;
   logic [TW-1:0]    tries_left;
   logic [1:0]       state;
   logic             reveal_on;
   logic [6:0]       anim_leds;

   // Board I/O side: drives buttons/switches, observes the game outputs
   modport master (
      output store_n, submit_n, reveal_n, secret_in, guess_in,
      input  secret_out, eq, gt, lt, tries_left, state, reveal_on, anim_leds
   );

   // Engine side
   modport slave (
      input  store_n, submit_n, reveal_n, secret_in, guess_in,
      output secret_out, eq, gt, lt, tries_left, state, reveal_on, anim_leds
   );
endinterface

// File: rtl/guess_game_engine.sv
// Guessing game engine: button synchronisation and edge detection, secret
// storage, guess scoring with a limited number of tries, win/lose states,
// reveal toggle and the win fill animation.
module guess_game_engine #(
   parameter int WIDTH         = 4,
   parameter int MAX_TRIES     = 7,
   parameter int ANIM_DIV_BITS = 23
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   guess_game_if.slave bus
);
   localparam int TW = $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WON  = 2'b10,
      S_LOST = 2'b11
   } state_t;

   // Bit 0 = store, bit 1 = submit, bit 2 = reveal
   logic [2:0]               r_sync1;
   logic [2:0]               r_sync2;
   logic [2:0]               r_sync_d;
   logic [2:0]               w_btn_raw;
   logic [2:0]               w_evt;
   logic                     w_store;
   logic                     w_submit;
   logic                     w_reveal;
   logic                     w_score;
   logic                     w_eq;
   logic                     w_gt;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [WIDTH-1:0]         r_secret;
   logic                     r_eq;
   logic                     r_gt;
   logic                     r_lt;
   logic [TW-1:0]            r_tries;
   logic                     r_reveal;
   logic [ANIM_DIV_BITS-1:0] r_presc;
   logic [2:0]               r_step;

   // Fill pattern from bit 0 for steps 0..6; step 7 is the blank frame
   function automatic logic [6:0] anim_pattern(input logic [2:0] s);
      logic [7:0] f;
      f = (8'd2 << s) - 8'd1;
      return (s == 3'd7) ? 7'd0 : f[6:0];
   endfunction

   assign w_btn_raw = {bus.reveal_n, bus.submit_n, bus.store_n};

   // Two-flop synchronisers plus a delayed copy for falling-edge detection;
   // reset to released so nothing fires when reset lifts
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_sync1  <= 3'b111;
         r_sync2  <= 3'b111;
         r_sync_d <= 3'b111;
      end else begin
         r_sync1  <= w_btn_raw;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_evt    = r_sync_d & ~r_sync2;
   assign w_store  = w_evt[0];
   // A store in the same cycle takes priority and swallows the submit
   assign w_submit = w_evt[1] & ~w_evt[0];
   assign w_reveal = w_evt[2];
   assign w_score  = w_submit && (r_state == S_PLAY);
   assign w_eq     = (bus.guess_in == r_secret);
   assign w_gt     = (bus.guess_in > r_secret);

   // Round state register
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Round progression: store (re)starts, a scored guess wins, loses or continues
   always_comb begin
      w_state_nxt = r_state;
      if (w_store) begin
         w_state_nxt = S_PLAY;
      end else if (w_score) begin
         if (w_eq)                      w_state_nxt = S_WON;
         else if (r_tries == TW'(1))    w_state_nxt = S_LOST;
         else                           w_state_nxt = S_PLAY;
      end
   end

   // Secret, score flags and remaining tries
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_secret <= '0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_tries  <= '0;
      end else if (w_store) begin
         r_secret <= bus.secret_in;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_tries  <= TW'(MAX_TRIES);
      end else if (w_score) begin
         r_eq     <= w_eq;
         r_gt     <= w_gt;
         r_lt     <= ~w_eq & ~w_gt;
         r_tries  <= r_tries - TW'(1);
      end
   end

   // Reveal toggle flips on every reveal press regardless of state
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)         r_reveal <= 1'b0;
      else if (w_reveal) r_reveal <= ~r_reveal;
   end

   // Animation prescaler and step; held at zero outside WON so WON always starts at step 0
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_step  <= 3'd0;
      end else if (r_state != S_WON) begin
         r_presc <= '0;
         r_step  <= 3'd0;
      end else begin
         r_presc <= r_presc + ANIM_DIV_BITS'(1);
         if (&r_presc) r_step <= r_step + 3'd1;
      end
   end

   assign bus.secret_out = r_secret;
   assign bus.eq         = r_eq;
   assign bus.gt         = r_gt;
   assign bus.lt         = r_lt;
   assign bus.tries_left = r_tries;
   assign bus.state      = r_state;

   // Display decode from registers only: LOST forces the reveal, animation only in WON
   always_comb begin
      bus.reveal_on = r_reveal | (r_state == S_LOST);
      bus.anim_leds = 7'd0;
      if (r_state == S_WON) bus.anim_leds = anim_pattern(r_step);
   end
endmodule

// File: tb/tb_guess_game_engine.sv
// Bench for guess_game_engine: two instances (7 tries and 3 tries, fast
// animation) driven by the same buttons and switches, compared against a
// behavioural model of the game rules.
module tb_guess_game_engine;
   logic       clk;
   logic       rst;
   logic       r_store_n;
   logic       r_submit_n;
   logic       r_reveal_n;
   logic [3:0] r_secret_sw;
   logic [3:0] r_guess;

   int checks   = 0;
   int failures = 0;

   // Behavioural model; index 0 = 7-try game, index 1 = 3-try game
   int maxt[2] = '{7, 3};
   int m_state[2];
   int m_sec[2];
   int m_tries[2];
   int m_eq[2];
   int m_gt[2];
   int m_lt[2];
   int m_tog;

   guess_game_if #(.WIDTH(4), .MAX_TRIES(7)) if7 ();
   guess_game_if #(.WIDTH(4), .MAX_TRIES(3)) if3 ();

   assign if7.store_n   = r_store_n;
   assign if7.submit_n  = r_submit_n;
   assign if7.reveal_n  = r_reveal_n;
   assign if7.secret_in = r_secret_sw;
   assign if7.guess_in  = r_guess;
   assign if3.store_n   = r_store_n;
   assign if3.submit_n  = r_submit_n;
   assign if3.reveal_n  = r_reveal_n;
   assign if3.secret_in = r_secret_sw;
   assign if3.guess_in  = r_guess;

   guess_game_engine #(.WIDTH(4), .MAX_TRIES(7), .ANIM_DIV_BITS(2)) dut7 (
      .CLOCK_50(clk), .reset(rst), .bus(if7)
   );
   guess_game_engine #(.WIDTH(4), .MAX_TRIES(3), .ANIM_DIV_BITS(2)) dut3 (
      .CLOCK_50(clk), .reset(rst), .bus(if3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int anim_exp(input int s);
      return (s < 7) ? ((1 << (s + 1)) - 1) : 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0; m_sec[d] = 0; m_tries[d] = 0;
         m_eq[d] = 0; m_gt[d] = 0; m_lt[d] = 0;
      end
      m_tog = 0;
   endtask

   task automatic model_evt(input bit st, input bit sb, input bit rv);
      for (int d = 0; d < 2; d++) begin
         if (st) begin
            m_sec[d] = int'(r_secret_sw); m_tries[d] = maxt[d]; m_state[d] = 1;
            m_eq[d] = 0; m_gt[d] = 0; m_lt[d] = 0;
         end else if (sb && m_state[d] == 1) begin
            m_eq[d] = (int'(r_guess) == m_sec[d]) ? 1 : 0;
            m_gt[d] = (int'(r_guess) >  m_sec[d]) ? 1 : 0;
            m_lt[d] = (int'(r_guess) <  m_sec[d]) ? 1 : 0;
            m_tries[d] = m_tries[d] - 1;
            if (m_eq[d] == 1)       m_state[d] = 2;
            else if (m_tries[d] == 0) m_state[d] = 3;
         end
      end
      if (rv) m_tog = 1 - m_tog;
   endtask

   task automatic check_dut(input int d, input string tag, input logic [1:0] st,
                            input logic [3:0] sec, input logic eq, input logic gt,
                            input logic lt, input logic [2:0] tr, input logic rv,
                            input logic [6:0] an);
      string p;
      p = $sformatf("%s/d%0d", tag, d);
      chk({p, ".state"},  32'(st),  32'(m_state[d]));
      chk({p, ".secret"}, 32'(sec), 32'(m_sec[d]));
      chk({p, ".eq"},     32'(eq),  32'(m_eq[d]));
      chk({p, ".gt"},     32'(gt),  32'(m_gt[d]));
      chk({p, ".lt"},     32'(lt),  32'(m_lt[d]));
      chk({p, ".tries"},  32'(tr),  32'(m_tries[d]));
      chk({p, ".reveal"}, 32'(rv),  32'((m_tog == 1 || m_state[d] == 3) ? 1 : 0));
      if (m_state[d] != 2) chk({p, ".anim"}, 32'(an), 32'(0));
   endtask

   task automatic check_all(input string tag);
      check_dut(0, tag, if7.state, if7.secret_out, if7.eq, if7.gt, if7.lt,
                3'(if7.tries_left), if7.reveal_on, if7.anim_leds);
      check_dut(1, tag, if3.state, if3.secret_out, if3.eq, if3.gt, if3.lt,
                3'(if3.tries_left), if3.reveal_on, if3.anim_leds);
   endtask

   task automatic press(input bit st, input bit sb, input bit rv, input int hold);
      @(negedge clk);
      r_store_n  = ~st;
      r_submit_n = ~sb;
      r_reveal_n = ~rv;
      repeat (hold) @(negedge clk);
      r_store_n  = 1'b1;
      r_submit_n = 1'b1;
      r_reveal_n = 1'b1;
      repeat (3) @(negedge clk);
      model_evt(st, sb, rv);
   endtask

   initial begin
      int sel;
      bit st, sb, rv;
      rst = 1'b1;
      r_store_n = 1'b1; r_submit_n = 1'b1; r_reveal_n = 1'b1;
      r_secret_sw = 4'd0; r_guess = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      @(negedge clk);

      // Store latency: event seen after edge k+1, outputs change at edge k+2
      r_secret_sw = 4'd5;
      r_store_n = 1'b0;
      @(negedge clk);
      chk("lat_k0.state", 32'(if7.state), 32'(0));
      @(negedge clk);
      chk("lat_k1.state", 32'(if7.state), 32'(0));
      @(negedge clk);
      chk("lat_k2.state", 32'(if7.state), 32'(1));
      r_store_n = 1'b1;
      repeat (3) @(negedge clk);
      model_evt(1, 0, 0);
      check_all("store5");

      r_guess = 4'd9; press(0, 1, 0, 1); check_all("guess9");
      r_guess = 4'd2; press(0, 1, 0, 1); check_all("guess2");

      // Winning guess (last try for the 3-try game), then watch the animation
      r_guess = 4'd5;
      @(negedge clk);
      r_submit_n = 1'b0;
      repeat (3) @(negedge clk);
      r_submit_n = 1'b1;
      model_evt(0, 1, 0);
      check_all("win");
      for (int i = 0; i < 36; i++) begin
         chk($sformatf("anim7_%0d", i), 32'(if7.anim_leds), 32'(anim_exp((i / 4) % 8)));
         chk($sformatf("anim3_%0d", i), 32'(if3.anim_leds), 32'(anim_exp((i / 4) % 8)));
         @(negedge clk);
      end

      r_guess = 4'd3; press(0, 1, 0, 1); check_all("won_submit_ignored");

      // Losing round on the 3-try game
      r_secret_sw = 4'd5; press(1, 0, 0, 1); check_all("restart5");
      for (int i = 0; i < 3; i++) begin
         r_guess = 4'($urandom_range(6, 15));
         press(0, 1, 0, 1);
         check_all($sformatf("wrong%0d", i));
      end
      chk("lost.state", 32'(if3.state), 32'(3));
      chk("lost.reveal", 32'(if3.reveal_on), 32'(1));
      r_guess = 4'd5; press(0, 1, 0, 1); check_all("lost_submit");
      r_secret_sw = 4'hA; press(1, 0, 0, 1); check_all("storeA");

      // Store and submit together, then a long held submit
      r_guess = 4'd1; press(0, 1, 0, 1); check_all("one_guess");
      r_guess = 4'd2; press(1, 1, 0, 1); check_all("store_and_submit");
      r_guess = 4'd3; press(0, 1, 0, 12); check_all("held_submit");

      // Randomised play
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         st = (sel < 2) || (sel == 9);
         sb = (sel >= 2 && sel < 8) || (sel == 9);
         rv = (sel == 8);
         if (st) r_secret_sw = 4'($urandom_range(0, 15));
         r_guess = 4'($urandom_range(0, 15));
         press(st, sb, rv, int'($urandom_range(1, 4)));
         check_all($sformatf("rand%0d", n));
      end

      // Asynchronous reset mid-round with reveal shown
      r_secret_sw = 4'd7; press(1, 0, 0, 1);
      if (m_tog == 0) press(0, 0, 1, 1);
      check_all("pre_reset");
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) press(0, 0, 1, 1);
      check_all("three_reveals");
      chk("three_reveals.on", 32'(if7.reveal_on), 32'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
